// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates tags at dispatch, captures CDB
// results, retires one head entry per cycle and raises flush on a mispredicted branch.
module reorder_buffer #(
   parameter int ROB_SIZE      = 8,
   parameter int TAG_WIDTH     = 4,
   parameter int REG_NUM_WIDTH = 5
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     dec_valid,
   input  logic [1:0]               dec_type,
   input  logic [REG_NUM_WIDTH-1:0] dec_rd,
   output logic [TAG_WIDTH-1:0]     dec_tag_out,
   output logic                     full_out,
   input  logic                     cdb_valid,
   input  logic [TAG_WIDTH-1:0]     cdb_tag,
   input  logic [31:0]              cdb_value,
   input  logic                     cdb_mispredict,
   input  logic [31:0]              cdb_target,
   input  logic [TAG_WIDTH-1:0]     query1_tag,
   input  logic [TAG_WIDTH-1:0]     query2_tag,
   output logic                     query1_ready,
   output logic                     query2_ready,
   output logic [31:0]              query1_value,
   output logic [31:0]              query2_value,
   output logic                     rob_valid,
   output logic [REG_NUM_WIDTH-1:0] rob_rd,
   output logic [31:0]              rob_value,
   output logic [TAG_WIDTH-1:0]     rob_dependency,
   output logic                     store_commit_out,
   output logic                     need_flush_out,
   output logic [31:0]              flush_pc_out
);
   localparam int PTR_W = $clog2(ROB_SIZE);
   localparam int CNT_W = $clog2(ROB_SIZE + 1);
   localparam logic [TAG_WIDTH-1:0] NO_DEP = '1;
   localparam logic [1:0] TYPE_REG    = 2'd0;
   localparam logic [1:0] TYPE_BRANCH = 2'd1;
   localparam logic [1:0] TYPE_STORE  = 2'd2;

   logic [ROB_SIZE-1:0]      busy;
   logic [ROB_SIZE-1:0]      ready;
   logic [ROB_SIZE-1:0]      mispredict;
   logic [1:0]               ent_type   [ROB_SIZE];
   logic [REG_NUM_WIDTH-1:0] ent_rd     [ROB_SIZE];
   logic [31:0]              ent_value  [ROB_SIZE];
   logic [31:0]              ent_target [ROB_SIZE];

   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic             accept, commit, do_flush;
   logic [PTR_W-1:0] head_next, tail_next;

   assign full_out    = (count == CNT_W'(ROB_SIZE));
   assign dec_tag_out = TAG_WIDTH'(tail);
   assign accept      = dec_valid && !full_out;
   assign commit      = busy[head] && ready[head];
   assign do_flush    = commit && (ent_type[head] == TYPE_BRANCH) && mispredict[head];
   assign head_next   = (head == PTR_W'(ROB_SIZE - 1)) ? '0 : head + 1'b1;
   assign tail_next   = (tail == PTR_W'(ROB_SIZE - 1)) ? '0 : tail + 1'b1;

   // Stored result wins; otherwise bypass a CDB broadcast of the same tag this cycle.
   function automatic logic [32:0] lookup(input logic [TAG_WIDTH-1:0] tag);
      logic [32:0] res;
      res = '0;
      if (tag != NO_DEP) begin
         for (int i = 0; i < ROB_SIZE; i++)
            if (tag == TAG_WIDTH'(i) && busy[i] && ready[i])
               res = {1'b1, ent_value[i]};
         if (!res[32] && cdb_valid && cdb_tag == tag)
            res = {1'b1, cdb_value};
      end
      return res;
   endfunction

   always_comb begin
      {query1_ready, query1_value} = lookup(query1_tag);
      {query2_ready, query2_value} = lookup(query2_tag);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head             <= '0;
         tail             <= '0;
         count            <= '0;
         busy             <= '0;
         ready            <= '0;
         mispredict       <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            ent_type[i]   <= TYPE_REG;
            ent_rd[i]     <= '0;
            ent_value[i]  <= '0;
            ent_target[i] <= '0;
         end
         rob_valid        <= 1'b0;
         rob_rd           <= '0;
         rob_value        <= '0;
         rob_dependency   <= '0;
         store_commit_out <= 1'b0;
         need_flush_out   <= 1'b0;
         flush_pc_out     <= '0;
      end else if (rdy_in) begin
         rob_valid        <= 1'b0;
         store_commit_out <= 1'b0;
         need_flush_out   <= 1'b0;
         if (commit) begin
            rob_rd         <= ent_rd[head];
            rob_value      <= ent_value[head];
            rob_dependency <= TAG_WIDTH'(head);
         end
         if (do_flush) begin
            // Younger work is squashed, including this cycle's dispatch and writeback.
            need_flush_out <= 1'b1;
            flush_pc_out   <= ent_target[head];
            busy           <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
         end else begin
            if (accept) begin
               busy[tail]     <= 1'b1;
               ready[tail]    <= 1'b0;
               ent_type[tail] <= (dec_type == TYPE_BRANCH || dec_type == TYPE_STORE) ?
                                 dec_type : TYPE_REG;
               ent_rd[tail]   <= (dec_type == TYPE_REG) ? dec_rd : '0;
               tail           <= tail_next;
            end
            if (cdb_valid) begin
               for (int i = 0; i < ROB_SIZE; i++)
                  if (busy[i] && cdb_tag == TAG_WIDTH'(i)) begin
                     ready[i]      <= 1'b1;
                     ent_value[i]  <= cdb_value;
                     mispredict[i] <= cdb_mispredict;
                     ent_target[i] <= cdb_target;
                  end
            end
            if (commit) begin
               busy[head] <= 1'b0;
               head       <= head_next;
               if (ent_type[head] == TYPE_STORE)
                  store_commit_out <= 1'b1;
               else if (ent_type[head] == TYPE_REG)
                  rob_valid <= 1'b1;
            end
            count <= count + CNT_W'(accept) - CNT_W'(commit);
         end
      end
   end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between the decoder/dispatch stage and the register file.
- Allocates a tag per dispatched instruction and captures results from the common data bus (CDB).
- Retires at most one head entry per cycle, driving the register-file commit port: valid, rd, value, and the tag as dependency.
- Raises the pipeline-wide flush on a mispredicted branch reaching the head; also serves combinational operand look-ups for dispatch.

Parameters:
ROB_SIZE, 8, number of entries; legal range is 2 to 2^TAG_WIDTH-1.
TAG_WIDTH, 4, tag width; the all-ones value means "no dependency" and is never allocated.
REG_NUM_WIDTH, 5, architectural register index width.

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low = every register holds
dec_valid  in  1  dispatch request
dec_type  in  2  0=REG, 1=BRANCH, 2=STORE, 3=reserved (treated as REG with rd=0)
dec_rd  in  REG_NUM_WIDTH  destination register (ignored unless REG)
dec_tag_out  out  TAG_WIDTH  tag the request gets if accepted = tail (combinational)
full_out  out  1  count==ROB_SIZE (combinational from count)
cdb_valid  in  1  result broadcast
cdb_tag  in  TAG_WIDTH  producing entry
cdb_value  in  32  result value
cdb_mispredict  in  1  branch mispredicted (BRANCH entries only)
cdb_target  in  32  correct PC on mispredict
query1_tag, query2_tag  in  TAG_WIDTH  operand tags from rf
query1_ready, query2_ready  out  1  entry has a result, or CDB delivers that tag this cycle
query1_value, query2_value  out  32  result (CDB value bypassed)
rob_valid  out  1  registered commit pulse to rf
rob_rd  out  REG_NUM_WIDTH  committed rd
rob_value  out  32  committed value
rob_dependency  out  TAG_WIDTH  committed tag
store_commit_out  out  1  registered pulse: head STORE retired
need_flush_out  out  1  registered one-cycle flush
flush_pc_out  out  32  redirect PC, valid with need_flush_out

Behaviour:
- Per-entry state: busy, ready, type, rd, value, mispredict, target.
- Pointers: head and tail are ROB_SIZE-wrapping indices; count runs 0..ROB_SIZE.
- Reset: head=tail=count=0, all busy=0, every output register 0. Tag outputs follow combinational rules; with no busy entries the query ready outputs are 0 unless the CDB bypass applies.
- rdy_in=0: no state change; all registered outputs hold their values.
- Dispatch: accepted iff dec_valid && !full_out.
  - Entry[tail] gets busy=1, ready=0, type, and rd (forced to 0 unless REG).
  - tail advances by one and wraps from ROB_SIZE-1 to 0.
  - When full, a request is refused even if a commit happens the same cycle. The decoder must hold the request.
- Writeback: cdb_valid with a busy matching tag sets ready=1 and stores value, mispredict and target. A non-busy or all-ones tag is ignored.
- Commit: if entry[head] is busy && ready, the next edge does the following.
  - Sets rob_valid=1, or store_commit_out=1 for STORE.
  - Sets rob_rd, rob_value and rob_dependency=head, then clears busy and advances head.
  - BRANCH entries assert rob_valid=0.
  - Latency: CDB write at edge N, commit pulse visible after edge N+1. A result never commits in its own writeback cycle.
  - REG with rd=0 still pulses rob_valid; rf ignores x0.
- Mispredict: a committing BRANCH with mispredict=1 sets need_flush_out=1 and flush_pc_out=target for exactly one cycle. In the same edge it clears all busy bits and sets head=tail=count=0. Dispatch and writeback in that cycle are discarded.
- External flush: none. This block is the only source of need_flush.
- Simultaneous dispatch and commit: count stays unchanged. Dispatch alone: count+1; commit alone: count-1.
- Wrap-around: tags are raw indices. An index reused after wrap is a new instance; stale CDB tags cannot occur because issue stages flush with the ROB.
- Queries: a busy, ready entry returns its stored value. Otherwise a CDB match this cycle returns cdb_value with ready=1. Otherwise ready=0. The all-ones tag returns ready=0.
- Pulses: rob_valid, store_commit_out and need_flush_out deassert the cycle after each pulse unless a new event occurs.

Test Plan:
- Reset, then dispatch REG rd=5 → dec_tag_out=0. CDB tag0 value 0x1234 → next cycle rob_valid=1, rob_rd=5, rob_value=0x1234, rob_dependency=0, count back to 0.
- Out-of-order completion: dispatch tags 0,1,2; CDB order 2,1,0 → three commits in order 0,1,2 on consecutive cycles after tag0's writeback.
- Full: 8 dispatches → full_out=1; a 9th request with head ready is refused that cycle and accepted next. Its tag is 0 after the wrap.
- Bypass: query1_tag=3, busy and not ready, CDB tag3 value 0xDEAD same cycle → query1_ready=1, query1_value=0xDEAD.
- Mispredict: BRANCH at head with cdb_mispredict=1, target 0x80 and 3 younger entries → need_flush_out=1 and flush_pc_out=0x80 for one cycle, then count=0 and no rob_valid from younger entries.
- rdy_in=0 for 3 cycles during a pending commit → outputs and pointers frozen; commit completes on the first cycle rdy_in returns to 1.
